// File: rtl/stim_sweep_pkg.sv
// Shared types for the stimulus sweep controller: FSM states, log record layout, vector-count helper.
package stim_sweep_pkg;

  localparam int MAX_N_IN = 8;
  localparam int SETTLE_W = 8;

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, EMIT, DONE} sweep_state_e;

  // One logged record; vector is sized for the widest legal DUT.
  typedef struct packed {
    logic [MAX_N_IN-1:0] vec;
    logic                resp;
  } log_rec_t;

  function automatic int num_vec(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter with zero/one flags; load has priority over decrement.
// Latency: flags reflect the registered count; backpressure: none, dec is ignored at zero.
module sweep_settle_timer #(
  parameter int W = 8
) (
  input  logic         CK,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         one
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge CK) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);
  assign one  = (cnt_q == W'(1));

endmodule

// File: rtl/stim_sweep_ctrl.sv
// Exhaustive input sweep: applies each vector, settles SETTLE cycles, samples dut_out, logs {vector, response}.
// Latency: SETTLE+3 cycles per vector with log_ready high; done 2**N_IN*(SETTLE+3)+1 cycles after start.
// Backpressure: log_valid/log_data hold in EMIT until log_ready; golden compare under STIM_SWEEP_GOLDEN_CMP_EN.
module stim_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 log_valid,
  input  logic                 log_ready,
  output logic [N_IN:0]        log_data,
  output logic [2**N_IN-1:0]   resp_vec
`ifdef STIM_SWEEP_GOLDEN_CMP_EN
  ,
  input  logic [2**N_IN-1:0]   golden_vec,
  output logic                 mismatch,
  output logic [N_IN-1:0]      fail_idx
`endif
);

  import stim_sweep_pkg::*;

  localparam int            NUM_VEC  = num_vec(N_IN);
  localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'(NUM_VEC - 1);

  sweep_state_e  state_q, state_d;
  logic [N_IN:0] idx_q;
  logic          timer_load, timer_dec, timer_zero, timer_one;
  logic          sweep_go, sample_en;

  sweep_settle_timer #(.W(SETTLE_W)) u_settle_timer (
    .CK       (CK),
    .reset    (reset),
    .load     (timer_load),
    .load_val (SETTLE_W'(SETTLE)),
    .dec      (timer_dec),
    .zero     (timer_zero),
    .one      (timer_one)
  );

  // abort outranks start in IDLE
  assign sweep_go  = (state_q == IDLE) && start && !abort;
  assign sample_en = (state_q == SAMPLE) && !abort;
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    unique case (state_q)
      IDLE:   if (sweep_go) state_d = APPLY;
      APPLY: begin
        timer_load = 1'b1;
        state_d    = (SETTLE == 0) ? SAMPLE : stim_sweep_pkg::SETTLE;
      end
      stim_sweep_pkg::SETTLE: begin
        if (timer_one || timer_zero) state_d = SAMPLE;
        else                          timer_dec = 1'b1;
      end
      SAMPLE: state_d = EMIT;
      EMIT:   if (log_ready) state_d = (idx_q == LAST_IDX) ? DONE : APPLY;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  always_ff @(posedge CK) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      dut_in    <= '0;
      log_valid <= 1'b0;
      log_data  <= '0;
      resp_vec  <= '0;
    end else begin
      state_q <= state_d;
      if (sweep_go) begin
        resp_vec <= '0;
        idx_q    <= '0;
      end
      if (state_q == APPLY) dut_in <= idx_q[N_IN-1:0];
      if (sample_en) begin
        resp_vec[idx_q[N_IN-1:0]] <= dut_out;
        log_data  <= {idx_q[N_IN-1:0], dut_out};
        log_valid <= 1'b1;
      end
      // An aborted handshake is treated as not accepted
      if ((state_q == EMIT) && log_ready && !abort) begin
        log_valid <= 1'b0;
        if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
      end
      if (abort && (state_q != IDLE)) log_valid <= 1'b0;
    end
  end

`ifdef STIM_SWEEP_GOLDEN_CMP_EN
  // Only the first divergence from the golden signature is kept
  always_ff @(posedge CK) begin
    if (reset || sweep_go) begin
      mismatch <= 1'b0;
      fail_idx <= '0;
    end else if (sample_en && !mismatch && (dut_out != golden_vec[idx_q[N_IN-1:0]])) begin
      mismatch <= 1'b1;
      fail_idx <= idx_q[N_IN-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_stim_sweep_ctrl.sv
// Scoreboard bench for stim_sweep_ctrl: expected records queued at start, popped on each log handshake.
module tb_stim_sweep_ctrl;
  import stim_sweep_pkg::*;

  localparam int N_IN = 4;
  localparam int NV   = 16;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic            reset, start, abort, dut_out;
  logic            log_ready = 1'b1;
  logic            busy, done, log_valid;
  logic [N_IN-1:0] dut_in;
  logic [N_IN:0]   log_data;
  logic [NV-1:0]   resp_vec;

  logic            start0, abort0, dut_out0;
  logic            log_ready0 = 1'b1;
  logic            busy0, done0, log_valid0;
  logic [N_IN-1:0] dut_in0;
  logic [N_IN:0]   log_data0;
  logic [NV-1:0]   resp_vec0;

`ifdef STIM_SWEEP_GOLDEN_CMP_EN
  logic [NV-1:0]   golden_vec, golden_vec0;
  logic            mismatch, mismatch0;
  logic [N_IN-1:0] fail_idx, fail_idx0;
`endif

  int       mode;
  int       n_chk  = 0;
  int       n_fail = 0;
  int       pops   = 0;
  int       done_pulses = 0;
  int       recs0  = 0;
  int       stall_req = 0;
  int       stall_ack = 0;
  int       stall_left = 0;
  log_rec_t exp_q[$];

  assign dut_out  = (mode == 1) ? 1'b1 : ((mode == 2) && (dut_in == 4'd10)) ? 1'b1 : ^dut_in;
  assign dut_out0 = 1'b1;

  stim_sweep_ctrl #(.N_IN(N_IN), .SETTLE(1)) u_dut (
    .CK(CK), .reset(reset), .start(start), .abort(abort), .busy(busy), .done(done),
    .dut_in(dut_in), .dut_out(dut_out), .log_valid(log_valid), .log_ready(log_ready),
    .log_data(log_data), .resp_vec(resp_vec)
`ifdef STIM_SWEEP_GOLDEN_CMP_EN
    , .golden_vec(golden_vec), .mismatch(mismatch), .fail_idx(fail_idx)
`endif
  );

  stim_sweep_ctrl #(.N_IN(N_IN), .SETTLE(0)) u_dut0 (
    .CK(CK), .reset(reset), .start(start0), .abort(abort0), .busy(busy0), .done(done0),
    .dut_in(dut_in0), .dut_out(dut_out0), .log_valid(log_valid0), .log_ready(log_ready0),
    .log_data(log_data0), .resp_vec(resp_vec0)
`ifdef STIM_SWEEP_GOLDEN_CMP_EN
    , .golden_vec(golden_vec0), .mismatch(mismatch0), .fail_idx(fail_idx0)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_bit(input int m, input int i);
    logic [3:0] v;
    v = 4'(i);
    if (m == 1) return 1'b1;
    if ((m == 2) && (i == 10)) return 1'b1;
    return ^v;
  endfunction

  function automatic logic [NV-1:0] model_vec(input int m, input int upto);
    logic [NV-1:0] r;
    r = '0;
    for (int i = 0; i < upto; i++) r[i] = model_bit(m, i);
    return r;
  endfunction

  task automatic push_all(input int m);
    log_rec_t r;
    exp_q.delete();
    pops = 0;
    for (int i = 0; i < NV; i++) begin
      r.vec  = 8'(i);
      r.resp = model_bit(m, i);
      exp_q.push_back(r);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
  endtask

  task automatic run_main(input int m, input int exp_cyc, input string tag);
    int cyc;
    mode = m;
    push_all(m);
    @(negedge CK);
    pulse_start();
    cyc = 1;
    while ((done !== 1'b1) && (cyc < 2000)) begin
      @(posedge CK); #1;
      cyc++;
    end
    check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_resp_vec"}, 32'(resp_vec), 32'(model_vec(m, NV)));
    check({tag, "_records"}, 32'(pops), 32'(NV));
    @(posedge CK); #1;
    check({tag, "_done_one_cycle"}, 32'(done), 32'(0));
    check({tag, "_idle_busy"}, 32'(busy), 32'(0));
  endtask

  // Scoreboard pop and log_ready stall generation
  always @(negedge CK) begin
    log_rec_t e;
    if (done === 1'b1) done_pulses++;
    if (log_valid && !log_ready) begin
      if (stall_left == 0) begin
        log_ready = 1'b1;
      end else begin
        check("stall_log_data", 32'(log_data), 32'(5'b01111));
        check("stall_dut_in", 32'(dut_in), 32'(7));
        stall_left--;
      end
    end else if ((stall_req != stall_ack) && busy && !log_valid && (dut_in == 4'd7)) begin
      log_ready  = 1'b0;
      stall_left = 5;
      stall_ack  = stall_req;
    end
    if (!reset && log_valid && log_ready && !abort) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("log_record", 32'(log_data), 32'({e.vec[N_IN-1:0], e.resp}));
        pops++;
      end
    end
  end

  always @(negedge CK) begin
    if (log_valid0 && log_ready0) begin
      check("t4_rec_vec", 32'(log_data0[N_IN:1]), 32'(recs0));
      check("t4_rec_resp", 32'(log_data0[0]), 32'(1));
      recs0++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, cyc, dp;
    reset = 1'b1; start = 1'b0; abort = 1'b0; start0 = 1'b0; abort0 = 1'b0; mode = 0;
`ifdef STIM_SWEEP_GOLDEN_CMP_EN
    golden_vec = 16'h6996; golden_vec0 = '1;
`endif
    repeat (3) @(posedge CK);
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_dut_in", 32'(dut_in), 32'(0));
    check("rst_log_valid", 32'(log_valid), 32'(0));
    check("rst_log_data", 32'(log_data), 32'(0));
    check("rst_resp_vec", 32'(resp_vec), 32'(0));
    reset = 1'b0;
    @(posedge CK); #1;

    // Baseline parity sweep
    run_main(0, 65, "t1");
`ifdef STIM_SWEEP_GOLDEN_CMP_EN
    check("t1_no_mismatch", 32'(mismatch), 32'(0));
`endif

    // Logger stalls the vector-7 record for 5 cycles
    stall_req++;
    run_main(0, 70, "t2");
    check("t2_stall_taken", 32'(stall_ack), 32'(stall_req));

    // Abort during SETTLE of vector 9
    mode = 0;
    push_all(0);
    pulse_start();
    n = 0;
    while (!(busy && (dut_in == 4'd9)) && (n < 500)) begin
      @(posedge CK); #1;
      n++;
    end
    check("t3_reach_v9", 32'(n < 500), 32'(1));
    dp = done_pulses;
    abort = 1'b1;
    @(posedge CK); #1;
    abort = 1'b0;
    check("t3_abort_busy", 32'(busy), 32'(0));
    check("t3_abort_valid", 32'(log_valid), 32'(0));
    repeat (5) @(posedge CK);
    #1;
    check("t3_no_done", 32'(done_pulses), 32'(dp));
    check("t3_partial_resp", 32'(resp_vec), 32'(model_vec(0, 9)));
    check("t3_partial_recs", 32'(pops), 32'(9));
    run_main(0, 65, "t3_restart");

    // start with abort in IDLE stays idle
    start = 1'b1; abort = 1'b1;
    @(posedge CK); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 32'(busy), 32'(0));

    // SETTLE=0 instance, DUT tied high
    @(negedge CK);
    start0 = 1'b1;
    @(posedge CK); #1;
    start0 = 1'b0;
    cyc = 1;
    while ((done0 !== 1'b1) && (cyc < 2000)) begin
      @(posedge CK); #1;
      cyc++;
    end
    check("t4_done_cycle", 32'(cyc), 32'(49));
    check("t4_resp_vec", 32'(resp_vec0), 32'(16'hFFFF));
    check("t4_records", 32'(recs0), 32'(16));

    // Reset during EMIT of vector 3; start while busy is ignored
    mode = 0;
    push_all(0);
    pulse_start();
    n = 0;
    while (!(busy && (dut_in == 4'd1)) && (n < 500)) begin
      @(posedge CK); #1;
      n++;
    end
    pulse_start();
    n = 0;
    while (!(log_valid && (log_data[N_IN:1] == 4'd3)) && (n < 500)) begin
      @(posedge CK); #1;
      n++;
    end
    check("t5_reach_emit3", 32'(n < 500), 32'(1));
    dp = done_pulses;
    reset = 1'b1;
    @(posedge CK); #1;
    reset = 1'b0;
    check("t5_busy", 32'(busy), 32'(0));
    check("t5_done", 32'(done), 32'(0));
    check("t5_dut_in", 32'(dut_in), 32'(0));
    check("t5_log_valid", 32'(log_valid), 32'(0));
    check("t5_log_data", 32'(log_data), 32'(0));
    check("t5_resp_vec", 32'(resp_vec), 32'(0));
    check("t5_records_before_reset", 32'(pops), 32'(3));
    repeat (5) @(posedge CK);
    #1;
    check("t5_no_done", 32'(done_pulses), 32'(dp));
    exp_q.delete();

`ifdef STIM_SWEEP_GOLDEN_CMP_EN
    // Golden compare catches the forced vector-10 error
    run_main(2, 65, "t6");
    check("t6_mismatch", 32'(mismatch), 32'(1));
    check("t6_fail_idx", 32'(fail_idx), 32'(10));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
